// File: rtl/bus_response_router_pkg.sv
// Shared constants and types for the CPU-side bus response router.
package bus_response_router_pkg;

  localparam int unsigned NUM_SLV   = 2;
  localparam int unsigned SLV_IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned SLV_MEM   = 0;
  localparam int unsigned SLV_GPIO  = 1;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_response_router_if.sv
// CPU request/response plus decoder selects and per-slave handshake seen by the router.
interface bus_response_router_if;
  import bus_response_router_pkg::*;

  logic                m_req_valid;
  logic                m_req_ready;
  logic [31:0]         m_req_addr;
  logic                m_req_we;
  logic                m_rsp_valid;
  logic [31:0]         m_rsp_rdata;
  logic                m_rsp_err;
  logic                s0_sel_mem;
  logic                s1_sel_gpio;
  logic [NUM_SLV-1:0]  s_req_valid;
  logic [NUM_SLV-1:0]  s_req_ready;
  logic [NUM_SLV-1:0]  s_rsp_valid;
  logic [31:0]         s0_rsp_rdata;
  logic [31:0]         s1_rsp_rdata;

  // Router side
  modport slave (
    input  m_req_valid, m_req_addr, m_req_we, s0_sel_mem, s1_sel_gpio,
           s_req_ready, s_rsp_valid, s0_rsp_rdata, s1_rsp_rdata,
    output m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, s_req_valid
  );

  // Environment side: CPU, decoder and slaves
  modport master (
    output m_req_valid, m_req_addr, m_req_we, s0_sel_mem, s1_sel_gpio,
           s_req_ready, s_rsp_valid, s0_rsp_rdata, s1_rsp_rdata,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, s_req_valid
  );
endinterface

// File: rtl/bus_timeout_ctr.sv
// Wait-for-response timer: cleared outside WAIT, flags terminal count at TIMEOUT_CYCLES-1.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Holds at terminal count so a late cycle cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/bus_response_router.sv
// Steers one outstanding CPU request to mem/gpio, returns the slave response or a bus error.
module bus_response_router
  import bus_response_router_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_response_router_if.slave bus,
  output logic [31:0]          err_addr,
  output logic [7:0]           err_cnt
);
  logic [1:0]                  state;
  logic [SLV_IDX_W-1:0]        owner;
  logic [SLV_IDX_W-1:0]        owner_nxt;
  logic [31:0]                 addr_q;
  logic                        we_q;
  rsp_t                        rsp_q;

  logic [NUM_SLV-1:0]          sel;
  logic [NUM_SLV-1:0][31:0]    slv_rdata;
  logic                        idle, waiting, one_hot, req_map;
  logic                        map_fire, unmap_fire, owner_rsp, tmo, err_fire;
  logic [31:0]                 err_src_addr;

  assign sel[SLV_MEM]        = bus.s0_sel_mem;
  assign sel[SLV_GPIO]       = bus.s1_sel_gpio;
  assign slv_rdata[SLV_MEM]  = bus.s0_rsp_rdata;
  assign slv_rdata[SLV_GPIO] = bus.s1_rsp_rdata;

  assign idle    = (state == ST_IDLE);
  assign waiting = (state == ST_WAIT);
  assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign req_map = idle && bus.m_req_valid && one_hot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign bus.s_req_valid[gi] = req_map && sel[gi];
    end
  endgenerate

  always_comb begin
    owner_nxt = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (sel[i]) owner_nxt = SLV_IDX_W'(i);
  end

  // Unmapped or ambiguous selects are accepted at once and answered with an error.
  assign map_fire    = req_map && |(sel & bus.s_req_ready);
  assign unmap_fire  = idle && bus.m_req_valid && !one_hot;
  assign bus.m_req_ready = map_fire || unmap_fire;

  assign owner_rsp    = waiting && bus.s_rsp_valid[owner];
  assign err_fire     = unmap_fire || (waiting && !owner_rsp && tmo);
  assign err_src_addr = idle ? bus.m_req_addr : addr_q;

  bus_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!waiting),
    .en    (waiting),
    .tc    (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      owner           <= '0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      rsp_q           <= '0;
      bus.m_rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (map_fire) begin
            owner  <= owner_nxt;
            addr_q <= bus.m_req_addr;
            we_q   <= bus.m_req_we;
            state  <= ST_WAIT;
          end else if (unmap_fire) begin
            addr_q          <= bus.m_req_addr;
            rsp_q           <= '{rdata: ERR_RDATA, err: 1'b1};
            bus.m_rsp_valid <= 1'b1;
            state           <= ST_RESP;
          end
        end
        ST_WAIT: begin
          // Owner response beats a coincident timeout.
          if (owner_rsp) begin
            rsp_q           <= '{rdata: we_q ? 32'd0 : slv_rdata[owner], err: 1'b0};
            bus.m_rsp_valid <= 1'b1;
            state           <= ST_RESP;
          end else if (tmo) begin
            rsp_q           <= '{rdata: ERR_RDATA, err: 1'b1};
            bus.m_rsp_valid <= 1'b1;
            state           <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus.m_rsp_valid <= 1'b0;
          state           <= ST_IDLE;
        end
        default: begin
          bus.m_rsp_valid <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (err_fire) begin
      err_addr <= err_src_addr;
      err_cnt  <= sat_inc8(err_cnt);
    end
  end

  assign bus.m_rsp_rdata = rsp_q.rdata;
  assign bus.m_rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_bus_response_router.sv
// Directed bench for bus_response_router with TIMEOUT_CYCLES=8.
module tb_bus_response_router;
  logic        clk;
  logic        rst_n;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
  int          n_chk;
  int          n_err;

  bus_response_router_if bus();

  bus_response_router #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.m_req_valid  = 1'b0;
    bus.m_req_addr   = 32'd0;
    bus.m_req_we     = 1'b0;
    bus.s0_sel_mem   = 1'b0;
    bus.s1_sel_gpio  = 1'b0;
    bus.s_req_ready  = 2'b00;
    bus.s_rsp_valid  = 2'b00;
    bus.s0_rsp_rdata = 32'd0;
    bus.s1_rsp_rdata = 32'd0;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic sm, input logic sg,
                     input logic [1:0] rdy);
    bus.m_req_valid = 1'b1;
    bus.m_req_addr  = a;
    bus.m_req_we    = we;
    bus.s0_sel_mem  = sm;
    bus.s1_sel_gpio = sg;
    bus.s_req_ready = rdy;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle_bus();
    rst_n = 1'b0;
    #12;
    chk("rst_rsp_valid", {31'd0, bus.m_rsp_valid}, 32'd0);
    chk("rst_rdata",     bus.m_rsp_rdata, 32'd0);
    chk("rst_err",       {31'd0, bus.m_rsp_err}, 32'd0);
    chk("rst_err_addr",  err_addr, 32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // mem read, slave answers 3 cycles after accept
    req(32'h0000_0010, 1'b0, 1'b1, 1'b0, 2'b01);
    #1;
    chk("rd_s_req_valid", {30'd0, bus.s_req_valid}, 32'd1);
    chk("rd_ready",       {31'd0, bus.m_req_ready}, 32'd1);
    tick();
    idle_bus();
    chk("rd_wait_ready",  {31'd0, bus.m_req_ready}, 32'd0);
    chk("rd_wait_sreq",   {30'd0, bus.s_req_valid}, 32'd0);
    tick();
    tick();
    chk("rd_no_rsp_yet",  {31'd0, bus.m_rsp_valid}, 32'd0);
    bus.s_rsp_valid  = 2'b01;
    bus.s0_rsp_rdata = 32'h1234_5678;
    tick();
    idle_bus();
    chk("rd_rsp_valid",   {31'd0, bus.m_rsp_valid}, 32'd1);
    chk("rd_rdata",       bus.m_rsp_rdata, 32'h1234_5678);
    chk("rd_err",         {31'd0, bus.m_rsp_err}, 32'd0);
    tick();
    chk("rd_pulse_end",   {31'd0, bus.m_rsp_valid}, 32'd0);
    chk("rd_rdata_hold",  bus.m_rsp_rdata, 32'h1234_5678);

    // gpio write, slave not ready for 2 cycles
    req(32'h4000_0004, 1'b1, 1'b0, 1'b1, 2'b00);
    #1;
    chk("wr_sreq",        {30'd0, bus.s_req_valid}, 32'd2);
    chk("wr_not_ready0",  {31'd0, bus.m_req_ready}, 32'd0);
    tick();
    chk("wr_not_ready1",  {31'd0, bus.m_req_ready}, 32'd0);
    tick();
    bus.s_req_ready = 2'b10;
    #1;
    chk("wr_ready",       {31'd0, bus.m_req_ready}, 32'd1);
    tick();
    idle_bus();
    tick();
    bus.s_rsp_valid  = 2'b10;
    bus.s1_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    idle_bus();
    chk("wr_rsp_valid",   {31'd0, bus.m_rsp_valid}, 32'd1);
    chk("wr_rdata",       bus.m_rsp_rdata, 32'd0);
    chk("wr_err",         {31'd0, bus.m_rsp_err}, 32'd0);
    tick();

    // unmapped read
    req(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b11);
    #1;
    chk("um_ready",       {31'd0, bus.m_req_ready}, 32'd1);
    chk("um_sreq",        {30'd0, bus.s_req_valid}, 32'd0);
    tick();
    idle_bus();
    chk("um_rsp_valid",   {31'd0, bus.m_rsp_valid}, 32'd1);
    chk("um_err",         {31'd0, bus.m_rsp_err}, 32'd1);
    chk("um_rdata",       bus.m_rsp_rdata, 32'hDEAD_BEEF);
    chk("um_err_addr",    err_addr, 32'h8000_0000);
    chk("um_err_cnt",     {24'd0, err_cnt}, 32'd1);
    chk("um_sreq_resp",   {30'd0, bus.s_req_valid}, 32'd0);
    tick();
    chk("um_pulse_end",   {31'd0, bus.m_rsp_valid}, 32'd0);

    // both selects asserted is treated as unmapped
    req(32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'b11);
    #1;
    chk("both_sreq",      {30'd0, bus.s_req_valid}, 32'd0);
    tick();
    idle_bus();
    chk("both_err",       {31'd0, bus.m_rsp_err}, 32'd1);
    chk("both_err_cnt",   {24'd0, err_cnt}, 32'd2);
    tick();

    // gpio read timeout, with a stray mem response along the way
    req(32'h4000_0008, 1'b0, 1'b0, 1'b1, 2'b10);
    tick();
    idle_bus();
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin
        bus.s_rsp_valid  = 2'b01;
        bus.s0_rsp_rdata = 32'h5555_AAAA;
      end
      tick();
      idle_bus();
      chk($sformatf("tmo_quiet_%0d", k), {31'd0, bus.m_rsp_valid}, 32'd0);
    end
    tick();
    chk("tmo_rsp_valid",  {31'd0, bus.m_rsp_valid}, 32'd1);
    chk("tmo_err",        {31'd0, bus.m_rsp_err}, 32'd1);
    chk("tmo_rdata",      bus.m_rsp_rdata, 32'hDEAD_BEEF);
    chk("tmo_err_addr",   err_addr, 32'h4000_0008);
    chk("tmo_err_cnt",    {24'd0, err_cnt}, 32'd3);
    tick();

    // slave response on the timeout cycle wins
    req(32'h4000_000C, 1'b0, 1'b0, 1'b1, 2'b10);
    tick();
    idle_bus();
    for (int k = 1; k <= 7; k++) tick();
    chk("race_quiet",     {31'd0, bus.m_rsp_valid}, 32'd0);
    bus.s_rsp_valid  = 2'b10;
    bus.s1_rsp_rdata = 32'hA5A5_0001;
    tick();
    idle_bus();
    chk("race_rsp_valid", {31'd0, bus.m_rsp_valid}, 32'd1);
    chk("race_err",       {31'd0, bus.m_rsp_err}, 32'd0);
    chk("race_rdata",     bus.m_rsp_rdata, 32'hA5A5_0001);
    chk("race_err_cnt",   {24'd0, err_cnt}, 32'd3);
    tick();

    // 300 unmapped requests saturate the error counter
    for (int i = 0; i < 300; i++) begin
      req(32'hC000_0000 + i, 1'b0, 1'b0, 1'b0, 2'b00);
      tick();
      idle_bus();
      tick();
    end
    chk("sat_err_cnt",    {24'd0, err_cnt}, 32'd255);
    chk("sat_err_addr",   err_addr, 32'hC000_012B);

    // reset while waiting on mem, then a late response
    req(32'h0000_0020, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    idle_bus();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("arst_err_addr",  err_addr, 32'd0);
    chk("arst_rdata",     bus.m_rsp_rdata, 32'd0);
    chk("arst_rsp_valid", {31'd0, bus.m_rsp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.s_rsp_valid  = 2'b01;
    bus.s0_rsp_rdata = 32'h7777_7777;
    tick();
    idle_bus();
    chk("late_rsp_valid", {31'd0, bus.m_rsp_valid}, 32'd0);
    chk("late_rdata",     bus.m_rsp_rdata, 32'd0);
    tick();
    chk("late_rsp_valid2", {31'd0, bus.m_rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
